voice_sched: RTL and testbench
==============================

VOICE_SCHED -- requirements
Module: voice_sched

Interface
REQ-001 The block SHALL have parameters NVOICE, default 4, number of oscillator voices (power of two, >=2).
REQ-002 The block SHALL have parameters PCM_BITS 12, SPD_BITS 10, POS_TO_SPD_SHIFT 8, SPD_TO_POS_SHIFT 3, TICK_DIV 8, with the sample tick every 2^TICK_DIV clocks.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-007 cfg_voice  input  log2(NVOICE)  target voice index.
REQ-008 cfg_on  input  1  1 = start voice, 0 = stop voice.
REQ-009 cfg_spd_init  input  SPD_BITS  signed initial speed loaded on start.
REQ-010 pcm  output  PCM_BITS+log2(NVOICE)  signed mixed sample.
REQ-011 pcm_valid  output  1  one-cycle strobe, pcm updated.
REQ-012 busy  output  1  high while a sweep is in progress.

Function
REQ-013 A free-running TICK_DIV-bit counter SHALL assert tick for one cycle each time it equals 0.
REQ-014 The FSM SHALL have states IDLE, POS, SPD, OUT; IDLE->POS on tick with voice index v=0 and accumulator cleared.
REQ-015 In POS, if voice v is active, pos[v] SHALL become pos[v] + (spd[v] >>> SPD_TO_POS_SHIFT), sign-extended to PCM_BITS; go to SPD.
REQ-016 In SPD, if voice v is active, spd[v] SHALL become spd[v] - (pos[v] >>> POS_TO_SPD_SHIFT) using the pos[v] just updated, sign-extended to SPD_BITS; the accumulator SHALL add pos[v] (0 if inactive); then v+1 and POS, or OUT after v=NVOICE-1.
REQ-017 Inactive voices SHALL still consume their POS and SPD cycles; a sweep is exactly 2*NVOICE+1 cycles, POS through OUT.
REQ-018 In OUT, pcm SHALL take the accumulator value and pcm_valid SHALL pulse for one cycle; next state IDLE.
REQ-019 Shifts SHALL be arithmetic (floor); pos/spd arithmetic SHALL wrap modulo width with no saturation; the accumulator SHALL be exact at pcm width.
REQ-020 cfg_ready SHALL equal (state==IDLE) && !tick; a tick in the same cycle as cfg_valid SHALL win and the request SHALL wait.
REQ-021 On accept with cfg_on=1: pos[v]<=0, spd[v]<=cfg_spd_init, active[v]<=1; with cfg_on=0: pos[v]<=0, spd[v]<=0, active[v]<=0; restarting an active voice SHALL reload it.
REQ-022 busy SHALL be high exactly when state != IDLE.
REQ-023 Parameter legality: 2^TICK_DIV >= 2*NVOICE+2; otherwise a tick during a sweep is undefined and SHALL be flagged by an elaboration check.

Reset
REQ-024 rst SHALL force state IDLE, tick counter 0, all pos/spd/active 0, accumulator 0, pcm 0, pcm_valid 0, busy 0, immediately and mid-sweep.
REQ-025 After rst deasserts, the first tick SHALL occur on the first cycle the counter reads 0 (cycle 0 after release).

Configuration
REQ-026 Macro VOICE_SCHED_GAIN_EN defined: adds input cfg_att (2 bits), stored per voice on start, and the accumulator SHALL add pos[v] >>> att[v].
REQ-027 Macro undefined: no cfg_att port, no storage; behaviour equals att=0 for all voices.

Structure
REQ-028 Package voice_sched_pkg SHALL hold the FSM state typedef and default-parameter constants.
REQ-029 One combinational sub-module osc_step SHALL compute the next pos and spd for one voice; voice_sched instantiates it once and time-shares it.

Verification
REQ-030 Reset, no config -> cfg_ready=1 outside ticks; pcm_valid pulses every 256 cycles with pcm=0; busy high 9 cycles per sweep (NVOICE=4).
REQ-031 Start voice 0 spd 277 -> 1st sample pcm=34 (spd stays 277), 2nd sample pcm=68.
REQ-032 Start voice 0 spd -8 -> 1st sample pcm=-1, spd[0]=-7.
REQ-033 Start voices 0 and 1, both spd 277 -> 1st sample pcm=68; then stop voice 1 -> next sample pcm equals voice 0 alone (68+34=102).
REQ-034 Hold cfg_valid asserted from the tick cycle -> cfg_ready low for 10 cycles (tick + 9 sweep), accepted on the first IDLE cycle after OUT.
REQ-035 Assert rst during SPD of voice 2 -> next cycle busy=0, pcm=0, pcm_valid=0; all voices inactive; subsequent samples 0.

Source files
------------

// File: rtl/voice_sched_pkg.sv
// rtl/voice_sched_pkg.sv - default parameters and sweep FSM state type for voice_sched
package voice_sched_pkg;

  localparam int DEF_NVOICE           = 4;
  localparam int DEF_PCM_BITS         = 12;
  localparam int DEF_SPD_BITS         = 10;
  localparam int DEF_POS_TO_SPD_SHIFT = 8;
  localparam int DEF_SPD_TO_POS_SHIFT = 3;
  localparam int DEF_TICK_DIV         = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POS,
    ST_SPD,
    ST_OUT
  } state_e;

endpackage

// File: rtl/voice_sched_osc_step.sv
// rtl/voice_sched_osc_step.sv - combinational next position/speed for one oscillator voice
module osc_step #(
  parameter int PCM_BITS         = 12,
  parameter int SPD_BITS         = 10,
  parameter int POS_TO_SPD_SHIFT = 8,
  parameter int SPD_TO_POS_SHIFT = 3
) (
  input  logic signed [PCM_BITS-1:0] pos_i,
  input  logic signed [SPD_BITS-1:0] spd_i,
  output logic signed [PCM_BITS-1:0] pos_o,
  output logic signed [SPD_BITS-1:0] spd_o
);

  logic signed [SPD_BITS-1:0] spd_sh;
  logic signed [PCM_BITS-1:0] pos_sh;
  logic signed [PCM_BITS-1:0] dpos;
  logic signed [SPD_BITS-1:0] dspd;

  // spd_o uses pos_i as given: the caller feeds the already-advanced position in the SPD phase
  assign spd_sh = spd_i >>> SPD_TO_POS_SHIFT;
  assign pos_sh = pos_i >>> POS_TO_SPD_SHIFT;
  assign dpos   = PCM_BITS'(spd_sh);
  assign dspd   = SPD_BITS'(pos_sh);
  assign pos_o  = pos_i + dpos;
  assign spd_o  = spd_i - dspd;

endmodule

// File: rtl/voice_sched.sv
// rtl/voice_sched.sv - time-shared oscillator voice scheduler and mixer; VOICE_SCHED_GAIN_EN adds per-voice attenuation
module voice_sched
  import voice_sched_pkg::*;
#(
  parameter int NVOICE           = DEF_NVOICE,
  parameter int PCM_BITS         = DEF_PCM_BITS,
  parameter int SPD_BITS         = DEF_SPD_BITS,
  parameter int POS_TO_SPD_SHIFT = DEF_POS_TO_SPD_SHIFT,
  parameter int SPD_TO_POS_SHIFT = DEF_SPD_TO_POS_SHIFT,
  parameter int TICK_DIV         = DEF_TICK_DIV
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic [$clog2(NVOICE)-1:0]                 cfg_voice,
  input  logic                                      cfg_on,
  input  logic signed [SPD_BITS-1:0]                cfg_spd_init,
`ifdef VOICE_SCHED_GAIN_EN
  input  logic [1:0]                                cfg_att,
`endif
  output logic signed [PCM_BITS+$clog2(NVOICE)-1:0] pcm,
  output logic                                      pcm_valid,
  output logic                                      busy
);

  localparam int VW = $clog2(NVOICE);
  localparam int PW = PCM_BITS + VW;
  localparam logic [VW-1:0] LAST_V = VW'(NVOICE - 1);

  if (2**TICK_DIV < 2*NVOICE + 2) begin : g_bad_tick_div
    $error("voice_sched: 2**TICK_DIV must be at least 2*NVOICE+2");
  end
  if ((NVOICE < 2) || (2**VW != NVOICE)) begin : g_bad_nvoice
    $error("voice_sched: NVOICE must be a power of two and at least 2");
  end

  state_e                     state_q;
  logic [TICK_DIV-1:0]        tick_cnt_q;
  logic [VW-1:0]              v_q;
  logic signed [PW-1:0]       acc_q;
  logic signed [PW-1:0]       pcm_q;
  logic                       pcm_valid_q;
  logic signed [PCM_BITS-1:0] pos_q [NVOICE];
  logic signed [SPD_BITS-1:0] spd_q [NVOICE];
  logic [NVOICE-1:0]          active_q;
`ifdef VOICE_SCHED_GAIN_EN
  logic [1:0]                 att_q [NVOICE];
`endif

  logic                       tick;
  logic signed [PCM_BITS-1:0] pos_cur;
  logic signed [PCM_BITS-1:0] pos_att;
  logic signed [PW-1:0]       acc_add;
  logic signed [PCM_BITS-1:0] pos_d;
  logic signed [SPD_BITS-1:0] spd_d;

  assign tick      = (tick_cnt_q == '0);
  assign cfg_ready = (state_q == ST_IDLE) && !tick;
  assign busy      = (state_q != ST_IDLE);
  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;

  osc_step #(
    .PCM_BITS        (PCM_BITS),
    .SPD_BITS        (SPD_BITS),
    .POS_TO_SPD_SHIFT(POS_TO_SPD_SHIFT),
    .SPD_TO_POS_SHIFT(SPD_TO_POS_SHIFT)
  ) u_osc_step (
    .pos_i(pos_q[v_q]),
    .spd_i(spd_q[v_q]),
    .pos_o(pos_d),
    .spd_o(spd_d)
  );

  // In the SPD phase pos_q[v_q] already holds this sweep's advanced position
  assign pos_cur = pos_q[v_q];
`ifdef VOICE_SCHED_GAIN_EN
  assign pos_att = pos_cur >>> att_q[v_q];
`else
  assign pos_att = pos_cur;
`endif
  assign acc_add = active_q[v_q] ? PW'(pos_att) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      v_q         <= '0;
      acc_q       <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      active_q    <= '0;
      for (int i = 0; i < NVOICE; i++) begin
        pos_q[i] <= '0;
        spd_q[i] <= '0;
`ifdef VOICE_SCHED_GAIN_EN
        att_q[i] <= '0;
`endif
      end
    end else begin
      tick_cnt_q  <= tick_cnt_q + 1'b1;
      pcm_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_POS;
            v_q     <= '0;
            acc_q   <= '0;
          end else if (cfg_valid) begin
            pos_q[cfg_voice]    <= '0;
            spd_q[cfg_voice]    <= cfg_on ? cfg_spd_init : '0;
            active_q[cfg_voice] <= cfg_on;
`ifdef VOICE_SCHED_GAIN_EN
            att_q[cfg_voice]    <= cfg_on ? cfg_att : 2'd0;
`endif
          end
        end
        ST_POS: begin
          if (active_q[v_q]) pos_q[v_q] <= pos_d;
          state_q <= ST_SPD;
        end
        ST_SPD: begin
          if (active_q[v_q]) spd_q[v_q] <= spd_d;
          acc_q <= acc_q + acc_add;
          if (v_q == LAST_V) begin
            state_q <= ST_OUT;
          end else begin
            v_q     <= v_q + 1'b1;
            state_q <= ST_POS;
          end
        end
        ST_OUT: begin
          pcm_q       <= acc_q;
          pcm_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_sched.sv
// tb/tb_voice_sched.sv - directed self-checking bench for voice_sched
module tb_voice_sched;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [1:0]         cfg_voice = 2'd0;
  logic               cfg_on = 1'b0;
  logic signed [9:0]  cfg_spd_init = 10'sd0;
  logic signed [13:0] pcm;
  logic               pcm_valid;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_sched dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_voice   (cfg_voice),
    .cfg_on      (cfg_on),
    .cfg_spd_init(cfg_spd_init),
`ifdef VOICE_SCHED_GAIN_EN
    .cfg_att     (2'b00),
`endif
    .pcm         (pcm),
    .pcm_valid   (pcm_valid),
    .busy        (busy)
  );

  // Release lands on a falling edge, so the next rising edge is the first tick cycle
  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] v, input logic on, input logic signed [9:0] spd);
    int n = 0;
    @(negedge clk);
    cfg_voice = v;
    cfg_on = on;
    cfg_spd_init = spd;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_accept voice=%0d ready=%b required=1", v, cfg_ready);
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_pcm(output logic signed [13:0] val);
    int n = 0;
    @(negedge clk);
    while (!pcm_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (pcm_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pcm_timeout pcm_valid=%b required=1", pcm_valid);
    end
    val = pcm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (pcm !== 14'sd0) begin errors++; $display("FAIL reset_pcm got=%0d exp=0", pcm); end
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_pcm_valid got=%b exp=0", pcm_valid); end
  endtask

  task automatic test_idle_sweep();
    int nbusy = 0;
    logic signed [13:0] s;
    longint t1, t2;
    do_reset();
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL tick_ready got=%b exp=0", cfg_ready); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    checks += 2;
    if (nbusy != 9) begin errors++; $display("FAIL busy_cycles got=%0d exp=9", nbusy); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
    wait_pcm(s);
    t1 = $time;
    checks++;
    if (s !== 14'sd0) begin errors++; $display("FAIL idle_pcm got=%0d exp=0", s); end
    wait_pcm(s);
    t2 = $time;
    checks += 2;
    if (s !== 14'sd0) begin errors++; $display("FAIL idle_pcm2 got=%0d exp=0", s); end
    if (t2 - t1 != 64'd2560) begin errors++; $display("FAIL sample_period got=%0d exp=2560", t2 - t1); end
  endtask

  task automatic test_single_voice();
    logic signed [13:0] s;
    do_reset();
    do_cfg(2'd0, 1'b1, 10'sd277);
    wait_pcm(s);
    checks += 2;
    if (s !== 14'sd34) begin errors++; $display("FAIL single_pcm1 got=%0d exp=34", s); end
    if (dut.spd_q[0] !== 10'sd277) begin errors++; $display("FAIL single_spd got=%0d exp=277", dut.spd_q[0]); end
    wait_pcm(s);
    checks++;
    if (s !== 14'sd68) begin errors++; $display("FAIL single_pcm2 got=%0d exp=68", s); end
  endtask

  task automatic test_negative_speed();
    logic signed [13:0] s;
    do_reset();
    do_cfg(2'd0, 1'b1, -10'sd8);
    wait_pcm(s);
    checks += 2;
    if (s !== -14'sd1) begin errors++; $display("FAIL neg_pcm got=%0d exp=-1", s); end
    if (dut.spd_q[0] !== -10'sd7) begin errors++; $display("FAIL neg_spd got=%0d exp=-7", dut.spd_q[0]); end
  endtask

  task automatic test_two_voices();
    logic signed [13:0] s;
    do_reset();
    do_cfg(2'd0, 1'b1, 10'sd277);
    do_cfg(2'd1, 1'b1, 10'sd277);
    wait_pcm(s);
    checks++;
    if (s !== 14'sd68) begin errors++; $display("FAIL two_pcm1 got=%0d exp=68", s); end
    wait_pcm(s);
    checks++;
    if (s !== 14'sd136) begin errors++; $display("FAIL two_pcm2 got=%0d exp=136", s); end
    do_cfg(2'd1, 1'b0, 10'sd0);
    wait_pcm(s);
    checks++;
    if (s !== 14'sd102) begin errors++; $display("FAIL stop_pcm got=%0d exp=102", s); end
  endtask

  task automatic test_back_to_back();
    int nlow = 0;
    logic signed [13:0] s;
    do_reset();
    cfg_voice = 2'd0;
    cfg_on = 1'b1;
    cfg_spd_init = 10'sd277;
    cfg_valid = 1'b1;
    while (!cfg_ready && nlow < 50) begin
      @(negedge clk);
      nlow++;
    end
    checks += 2;
    if (nlow != 10) begin errors++; $display("FAIL hold_ready_low got=%0d exp=10", nlow); end
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy got=%b exp=0", busy); end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_pcm(s);
    checks++;
    if (s !== 14'sd34) begin errors++; $display("FAIL hold_pcm got=%0d exp=34", s); end
  endtask

  task automatic test_reset_mid_sweep();
    logic signed [13:0] s;
    do_reset();
    do_cfg(2'd0, 1'b1, 10'sd277);
    do_cfg(2'd1, 1'b1, 10'sd277);
    wait_pcm(s);
    checks++;
    if (s !== 14'sd68) begin errors++; $display("FAIL mid_pre_pcm got=%0d exp=68", s); end
    // 246 cycles to the next tick, then six more lands on SPD of voice 2
    repeat (252) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (pcm !== 14'sd0) begin errors++; $display("FAIL mid_pcm got=%0d exp=0", pcm); end
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL mid_pcm_valid got=%b exp=0", pcm_valid); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_pcm(s);
    checks++;
    if (s !== 14'sd0) begin errors++; $display("FAIL post_rst_pcm1 got=%0d exp=0", s); end
    wait_pcm(s);
    checks++;
    if (s !== 14'sd0) begin errors++; $display("FAIL post_rst_pcm2 got=%0d exp=0", s); end
  endtask

  initial begin
    test_reset();
    test_idle_sweep();
    test_single_voice();
    test_negative_speed();
    test_two_voices();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
